// File: rtl/joy_scan_pkg.sv
// ----------------------------------------------------------------------------
// joy_scan_pkg
//   Shared types and helpers for the serial joystick scanner.
//   - scan_state_t : scanner FSM states
//   - STABLE_W     : width of the debounce frame counter (depth up to 15)
//   - width_for()  : counter width able to hold 0..count-1, never below 1
//   - idx_width()  : IDX_W for a chain of PLAYERS*BITS bits
//   - div_width()  : DIV_W for a CLK_DIV divider
// ----------------------------------------------------------------------------
package joy_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        LATCH,
        GAP
    } scan_state_t;

    localparam int STABLE_W = 4;

    // $clog2(1) is 0, which would give zero-width vectors for a 1-bit chain
    // or a 1-entry gap counter, so clamp to one bit.
    function automatic int width_for(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

    function automatic int idx_width(input int players, input int bits);
        return width_for(players * bits);
    endfunction

    function automatic int div_width(input int clk_div);
        return width_for(clk_div);
    endfunction

endpackage

// File: rtl/joy_scan_tick.sv
// ----------------------------------------------------------------------------
// joy_scan_tick
//   Free-running CLK_DIV divider producing the scanner's bit-rate tick.
//   The count runs 0..CLK_DIV-1 and tick is high while it sits on CLK_DIV-1.
//   Ports:
//     clk      in  system clock
//     reset_n  in  asynchronous active-low reset
//     clear    in  hold the count at 0 (scanner idle and not enabled)
//     tick     out one-cycle strobe every CLK_DIV cycles
// ----------------------------------------------------------------------------
module joy_scan_tick
    import joy_scan_pkg::*;
#(
    parameter int CLK_DIV = 20
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int DIV_W = div_width(CLK_DIV);
    localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // Gated by clear so a held divider can never leak a stray tick.
    assign tick = !clear && (count == LAST);

endmodule

// File: rtl/joy_serial_scan.sv
// ----------------------------------------------------------------------------
// joy_serial_scan
//   Serial joystick scanner for a chain of 74165-style PISO shift registers.
//   Each frame: pulse joy_load low for one tick, then clock PLAYERS*BITS bits
//   out of the chain (joy_clk low for one tick, sample, high for one tick),
//   latch and debounce the frame, then idle GAP_TICKS ticks.
//   Ports:
//     clk         in   system clock (40-50 MHz)
//     reset_n     in   asynchronous active-low reset
//     enable      in   run scanning; low returns to IDLE with outputs held
//     joy_data    in   serial data from the chain (already synchronised)
//     joy_clk     out  shift clock to the chain, idle high
//     joy_load    out  parallel load to the chain, active low, idle high
//     joystick    out  debounced buttons, player p at [p*BITS +: BITS]
//     frame_done  out  one-cycle pulse when a frame has been latched
// ----------------------------------------------------------------------------
module joy_serial_scan
    import joy_scan_pkg::*;
#(
    parameter int PLAYERS   = 2,
    parameter int BITS      = 12,
    parameter int CLK_DIV   = 20,
    parameter int GAP_TICKS = 64,
    parameter int DEBOUNCE  = 2,
    parameter int INVERT    = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      joy_data,
    output logic                      joy_clk,
    output logic                      joy_load,
    output logic [PLAYERS*BITS-1:0]   joystick,
    output logic                      frame_done
);

    localparam int NBITS = PLAYERS * BITS;
    localparam int IDX_W = idx_width(PLAYERS, BITS);
    localparam int GAP_W = width_for(GAP_TICKS);

    localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(NBITS - 1);
    localparam logic [GAP_W-1:0]    LAST_GAP   = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [STABLE_W-1:0] STABLE_MAX = STABLE_W'(DEBOUNCE - 1);
    localparam logic                DATA_INV   = (INVERT != 0);

    scan_state_t         state;
    logic [IDX_W-1:0]    idx;
    logic                phase_high;
    logic [GAP_W-1:0]    gap_count;
    logic [NBITS-1:0]    raw;
    logic [NBITS-1:0]    prev;
    logic [STABLE_W-1:0] stable;
    logic [STABLE_W-1:0] stable_next;
    logic                tick;
    logic                div_clear;
    logic                sample_bit;

    // The divider only free-runs in IDLE once enable is up, so the first
    // LOAD comes a full tick after enable is seen.
    assign div_clear = (state == IDLE) && !enable;

    joy_scan_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (div_clear),
        .tick    (tick)
    );

    assign sample_bit = joy_data ^ DATA_INV;

    // Frame-to-frame agreement counter: counts consecutive identical frames,
    // saturating at DEBOUNCE-1, and restarts on any difference.
    always_comb begin
        stable_next = '0;
        if (raw == prev) begin
            stable_next = (stable == STABLE_MAX) ? stable : stable + 1'b1;
        end
    end

    // Scanner FSM. Dropping enable in any active state wins over the tick
    // and parks the chain outputs high; raw/prev/stable/joystick are kept so
    // a resumed scan debounces as if the aborted frame never happened.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            idx        <= '0;
            phase_high <= 1'b0;
            gap_count  <= '0;
            raw        <= '0;
            prev       <= '0;
            stable     <= '0;
            joystick   <= '0;
            joy_clk    <= 1'b1;
            joy_load   <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (state != IDLE && !enable) begin
                state    <= IDLE;
                joy_clk  <= 1'b1;
                joy_load <= 1'b1;
            end else if (tick) begin
                unique case (state)
                    IDLE: begin
                        if (enable) begin
                            state    <= LOAD;
                            joy_load <= 1'b0;
                        end
                    end
                    LOAD: begin
                        state      <= SHIFT;
                        joy_load   <= 1'b1;
                        joy_clk    <= 1'b0;
                        idx        <= '0;
                        phase_high <= 1'b0;
                    end
                    SHIFT: begin
                        if (!phase_high) begin
                            // End of the low phase: data has had a full tick
                            // to settle since joy_clk fell.
                            raw[idx]   <= sample_bit;
                            phase_high <= 1'b1;
                            joy_clk    <= 1'b1;
                        end else if (idx == LAST_IDX) begin
                            state      <= LATCH;
                            prev       <= raw;
                            stable     <= stable_next;
                            frame_done <= 1'b1;
                            if (stable_next == STABLE_MAX) begin
                                joystick <= raw;
                            end
                        end else begin
                            idx        <= idx + 1'b1;
                            phase_high <= 1'b0;
                            joy_clk    <= 1'b0;
                        end
                    end
                    LATCH: begin
                        if (GAP_TICKS == 0) begin
                            state    <= LOAD;
                            joy_load <= 1'b0;
                        end else begin
                            state     <= GAP;
                            gap_count <= '0;
                        end
                    end
                    GAP: begin
                        if (gap_count == LAST_GAP) begin
                            state    <= LOAD;
                            joy_load <= 1'b0;
                        end else begin
                            gap_count <= gap_count + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_joy_serial_scan.sv
// ----------------------------------------------------------------------------
// tb_joy_serial_scan
//   Two scanners on one clock: dut_a (2 players x 12 bits, gap 8, debounce 2)
//   and dut_b (1 player x 16 bits, no gap, debounce 1), each reading from a
//   behavioural 74165 chain. Frames are predicted from the button pattern
//   the chain was loaded with and a history of latched frames.
// ----------------------------------------------------------------------------
module tb_joy_serial_scan;

    localparam int CLK_DIV  = 4;
    localparam int DEB_A    = 2;
    localparam int PERIOD_A = (2 + 2 * 24 + 8) * CLK_DIV;
    localparam int LAT_A    = (1 + 2 * 24) * CLK_DIV;
    localparam int PERIOD_B = (2 + 2 * 16) * CLK_DIV;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic        reset_n = 1'b1;
    logic        enable_a = 1'b0;
    logic        joy_data_a;
    logic        joy_clk_a;
    logic        joy_load_a;
    logic [23:0] joystick_a;
    logic        frame_done_a;
    logic [23:0] buttons_a = '0;
    logic [23:0] sr_a = '1;
    logic [23:0] loaded_a = '0;
    logic        clk_seen_a = 1'b1;

    logic        rst_b_n = 1'b1;
    logic        enable_b = 1'b0;
    logic        joy_data_b;
    logic        joy_clk_b;
    logic        joy_load_b;
    logic [15:0] joystick_b;
    logic        frame_done_b;
    logic [15:0] buttons_b = '0;
    logic [15:0] sr_b = '1;
    logic [15:0] loaded_b = '0;
    logic        clk_seen_b = 1'b1;
    bit          done_b = 1'b0;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    joy_serial_scan #(
        .PLAYERS(2), .BITS(12), .CLK_DIV(CLK_DIV), .GAP_TICKS(8), .DEBOUNCE(DEB_A), .INVERT(1)
    ) dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable_a),
        .joy_data   (joy_data_a),
        .joy_clk    (joy_clk_a),
        .joy_load   (joy_load_a),
        .joystick   (joystick_a),
        .frame_done (frame_done_a)
    );

    joy_serial_scan #(
        .PLAYERS(1), .BITS(16), .CLK_DIV(CLK_DIV), .GAP_TICKS(0), .DEBOUNCE(1), .INVERT(1)
    ) dut_b (
        .clk        (clk),
        .reset_n    (rst_b_n),
        .enable     (enable_b),
        .joy_data   (joy_data_b),
        .joy_clk    (joy_clk_b),
        .joy_load   (joy_load_b),
        .joystick   (joystick_b),
        .frame_done (frame_done_b)
    );

    // 74165 chains: parallel load while load is low (buttons are active-low
    // on the wire), shift toward bit 0 on each rising joy_clk.
    always @(posedge clk) begin
        if (!joy_load_a) begin
            sr_a     <= ~buttons_a;
            loaded_a <= buttons_a;
        end else if (joy_clk_a && !clk_seen_a) begin
            sr_a <= {1'b1, sr_a[23:1]};
        end
        clk_seen_a <= joy_clk_a;
    end
    assign joy_data_a = sr_a[0];

    always @(posedge clk) begin
        if (!joy_load_b) begin
            sr_b     <= ~buttons_b;
            loaded_b <= buttons_b;
        end else if (joy_clk_b && !clk_seen_b) begin
            sr_b <= {1'b1, sr_b[15:1]};
        end
        clk_seen_b <= joy_clk_b;
    end
    assign joy_data_b = sr_b[0];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference for dut_a: a history of latched frames that starts with one
    // all-zero frame after reset. The output takes a frame once the last
    // DEB_A frames in the history agree.
    logic [23:0] hist_a[$];
    logic [23:0] exp_a = '0;
    longint      last_fd_a = 0;
    bit          have_fd_a = 1'b0;
    int          epoch_a = 0;
    int          fd_epoch_a = 0;

    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_a    = {24'h0};
            exp_a     = '0;
            have_fd_a = 1'b0;
        end else if (frame_done_a) begin
            bit agree;
            hist_a.push_back(loaded_a);
            if (hist_a.size() > 16) void'(hist_a.pop_front());
            agree = (hist_a.size() >= DEB_A);
            for (int i = 1; i < DEB_A && agree; i++) begin
                if (hist_a[hist_a.size() - 1 - i] != loaded_a) agree = 1'b0;
            end
            if (agree) exp_a = loaded_a;
            checkOutput("joystick_a_frame", 32'(joystick_a), 32'(exp_a));
            if (have_fd_a && fd_epoch_a == epoch_a) begin
                checkOutput("period_a", 32'(cyc - last_fd_a), 32'(PERIOD_A));
            end
            last_fd_a  = cyc;
            have_fd_a  = 1'b1;
            fd_epoch_a = epoch_a;
        end
    end

    // dut_b debounces over a single frame, so it must show every frame.
    longint last_fd_b = 0;
    bit     have_fd_b = 1'b0;

    always @(negedge clk) begin
        if (rst_b_n && frame_done_b) begin
            checkOutput("joystick_b_frame", 32'(joystick_b), 32'(loaded_b));
            if (have_fd_b) checkOutput("period_b", 32'(cyc - last_fd_b), 32'(PERIOD_B));
            last_fd_b = cyc;
            have_fd_b = 1'b1;
        end
    end

    task automatic wait_frame_a();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done_a && n < 1000);
        if (!frame_done_a) checkOutput("frame_timeout_a", 32'(frame_done_a), 32'd1);
    endtask

    task automatic wait_frame_b();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done_b && n < 1000);
        if (!frame_done_b) checkOutput("frame_timeout_b", 32'(frame_done_b), 32'd1);
    endtask

    // Cycles from now until joy_load_a is seen low (bounded).
    task automatic cycles_to_load_a(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (joy_load_a && n < 400);
    endtask

    task automatic applyStimulus(input logic [23:0] pattern, input int frames);
        buttons_a = pattern;
        repeat (frames) wait_frame_a();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no completion, expected finish within budget");
        $fatal(1, "[TB] watchdog expired");
    end

    // dut_b: simple free-running scan with a fresh random pattern per frame.
    initial begin
        rst_b_n  = 1'b0;
        enable_b = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_b_joy_clk", 32'(joy_clk_b), 32'd1);
        checkOutput("rst_b_joystick", 32'(joystick_b), 32'd0);
        #2 rst_b_n = 1'b1;
        for (int f = 0; f < 12; f++) begin
            wait_frame_b();
            buttons_b = 16'($urandom);
        end
        wait_frame_b();
        done_b = 1'b1;
    end

    initial begin
        int n;
        int len;
        int falls;
        int fd_count;
        int hold;
        logic prev_clk;

        // Reset with enable already high and nothing pressed.
        reset_n  = 1'b0;
        enable_a = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checkOutput("rst_joy_clk", 32'(joy_clk_a), 32'd1);
            checkOutput("rst_joy_load", 32'(joy_load_a), 32'd1);
            checkOutput("rst_joystick", 32'(joystick_a), 32'd0);
            checkOutput("rst_frame_done", 32'(frame_done_a), 32'd0);
            @(negedge clk);
        end
        #2 reset_n = 1'b1;

        cycles_to_load_a(n);
        checkOutput("load_after_reset", 32'(n), 32'(CLK_DIV));
        len = 1;
        @(negedge clk);
        while (!joy_load_a && len < 100) begin
            len++;
            @(negedge clk);
        end
        checkOutput("first_load_len", 32'(len), 32'(CLK_DIV));

        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done_a && n < 1000);
        checkOutput("first_latency", 32'(n + len), 32'(LAT_A));
        wait_frame_a();
        checkOutput("released_joystick", 32'(joystick_a), 32'd0);

        // P0 bit 4 and P1 bit 0 pressed: needs two agreeing frames.
        buttons_a = 24'h001010;
        wait_frame_a();
        checkOutput("press_1st_frame", 32'(joystick_a), 32'd0);
        wait_frame_a();
        checkOutput("press_2nd_frame", 32'(joystick_a), 32'h001010);

        // One-frame glitch on P0 bit 3 must never reach the output.
        buttons_a = 24'h001018;
        wait_frame_a();
        buttons_a = 24'h001010;
        for (int i = 0; i < 3; i++) begin
            checkOutput("glitch_bit3", 32'(joystick_a[3]), 32'd0);
            wait_frame_a();
        end
        checkOutput("glitch_settled", 32'(joystick_a), 32'h001010);

        // Random patterns, each held 1..3 frames so some pass the debounce.
        hold = 0;
        for (int f = 0; f < 14; f++) begin
            if (hold == 0) begin
                buttons_a = 24'($urandom);
                hold = $urandom_range(1, 3);
            end
            hold--;
            wait_frame_a();
        end

        // Drop enable at SHIFT index 10.
        applyStimulus(24'hA5C3F0, 2);
        cycles_to_load_a(n);
        while (!joy_load_a && n < 800) begin
            @(negedge clk);
            n++;
        end
        falls = 0;
        prev_clk = 1'b1;
        while (falls < 11 && n < 800) begin
            if (prev_clk && !joy_clk_a) falls++;
            prev_clk = joy_clk_a;
            if (falls < 11) begin
                @(negedge clk);
                n++;
            end
        end
        checkOutput("drop_reached_idx10", 32'(falls), 32'd11);
        enable_a = 1'b0;
        epoch_a++;
        @(negedge clk);
        checkOutput("drop_joy_clk", 32'(joy_clk_a), 32'd1);
        checkOutput("drop_joy_load", 32'(joy_load_a), 32'd1);
        fd_count = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (frame_done_a) fd_count++;
        end
        checkOutput("drop_no_frame", 32'(fd_count), 32'd0);
        checkOutput("drop_hold", 32'(joystick_a), 32'(exp_a));
        checkOutput("drop_idle_clk", 32'(joy_clk_a), 32'd1);

        enable_a = 1'b1;
        cycles_to_load_a(n);
        checkOutput("reenable_load", 32'(n), 32'(CLK_DIV));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done_a && n < 1000);
        checkOutput("reenable_latency", 32'(n), 32'(LAT_A));
        applyStimulus(24'h5A0C33, 2);
        checkOutput("reenable_track", 32'(joystick_a), 32'h5A0C33);

        // One-cycle reset pulse in the middle of SHIFT.
        cycles_to_load_a(n);
        repeat (CLK_DIV + 10) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("pulse_joy_clk", 32'(joy_clk_a), 32'd1);
        checkOutput("pulse_joy_load", 32'(joy_load_a), 32'd1);
        checkOutput("pulse_joystick", 32'(joystick_a), 32'd0);
        checkOutput("pulse_frame_done", 32'(frame_done_a), 32'd0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        cycles_to_load_a(n);
        checkOutput("pulse_restart_load", 32'(n), 32'(CLK_DIV));
        wait_frame_a();
        checkOutput("post_reset_1st", 32'(joystick_a), 32'd0);
        wait_frame_a();
        checkOutput("post_reset_2nd", 32'(joystick_a), 32'h5A0C33);
        applyStimulus(24'($urandom), 3);

        n = 0;
        while (!done_b && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!done_b) checkOutput("b_timeout", 32'(done_b), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
